// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: load-use stalls,
// branch/jump squash, MULT/DIV busy sequencing and a saturating stall counter.
module hazard_stall_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs_Id,
    input  logic [4:0]  Rt_Id,
    input  logic [4:0]  Rt_Ex,
    input  logic        MemRead_Ex,
    input  logic        Branch_Taken_Id,
    input  logic        Jump_Id,
    input  logic        MD_Start_Id,
    input  logic        MD_IsDiv_Id,
    input  logic        MD_Use_Id,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IDEX_Flush,
    output logic        IFID_Flush,
    output logic        MD_Fire,
    output logic        MD_Busy,
    output logic        MD_Done,
    output logic [15:0] Stall_Cnt
);

    localparam int unsigned STALL_W = 16;
    localparam logic [CNT_W-1:0]   MUL_LOAD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0]   DIV_LOAD = CNT_W'(DIV_LAT);
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_md_done;
    logic [STALL_W-1:0]   r_stall_cnt;

    logic                 w_load_use;
    logic                 w_md_stall;
    logic                 w_stall;
    logic                 w_fire;

    // Hazard detection: load-use on a non-zero destination, or MULT/DIV traffic while busy
    always_comb begin
        w_load_use = MemRead_Ex && (Rt_Ex != 5'd0) &&
                     ((Rt_Ex == Rs_Id) || (Rt_Ex == Rt_Id));
        w_md_stall = (r_state == BUSY) && (MD_Start_Id || MD_Use_Id);
        w_stall    = w_load_use || w_md_stall;
        w_fire     = MD_Start_Id && !w_stall;
    end

    // Pipeline control; stall outranks branch/jump squash, reset forces a full bubble
    always_comb begin
        PC_Write   = 1'b1;
        IFID_Write = 1'b1;
        IDEX_Flush = 1'b0;
        IFID_Flush = Branch_Taken_Id || Jump_Id;
        MD_Fire    = w_fire;
        if (!rst) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            IDEX_Flush = 1'b1;
            IFID_Flush = 1'b1;
            MD_Fire    = 1'b0;
        end else if (w_stall) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            IDEX_Flush = 1'b1;
            IFID_Flush = 1'b0;
        end
    end

    // MULT/DIV busy FSM with countdown, done pulse and saturating stall counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_md_done   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_md_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        r_cnt   <= MD_IsDiv_Id ? DIV_LOAD : MUL_LOAD;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_cnt     <= '0;
                        r_state   <= IDLE;
                        r_md_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
            if (w_stall && (r_stall_cnt != STALL_MAX)) begin
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
            end
        end
    end

    assign MD_Busy   = (r_state == BUSY);
    assign MD_Done   = r_md_done;
    assign Stall_Cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (MUL_LAT=4, DIV_LAT=32).
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  Rs_Id, Rt_Id, Rt_Ex;
    logic        MemRead_Ex, Branch_Taken_Id, Jump_Id;
    logic        MD_Start_Id, MD_IsDiv_Id, MD_Use_Id;
    logic        PC_Write, IFID_Write, IDEX_Flush, IFID_Flush;
    logic        MD_Fire, MD_Busy, MD_Done;
    logic [15:0] Stall_Cnt;

    int total = 0;
    int bad   = 0;

    hazard_stall_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .Rs_Id(Rs_Id), .Rt_Id(Rt_Id), .Rt_Ex(Rt_Ex),
        .MemRead_Ex(MemRead_Ex), .Branch_Taken_Id(Branch_Taken_Id), .Jump_Id(Jump_Id),
        .MD_Start_Id(MD_Start_Id), .MD_IsDiv_Id(MD_IsDiv_Id), .MD_Use_Id(MD_Use_Id),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Flush(IDEX_Flush),
        .IFID_Flush(IFID_Flush), .MD_Fire(MD_Fire), .MD_Busy(MD_Busy),
        .MD_Done(MD_Done), .Stall_Cnt(Stall_Cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance past the next rising edge; inputs may then be changed
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        Rs_Id = 5'd0; Rt_Id = 5'd0; Rt_Ex = 5'd0;
        MemRead_Ex = 1'b0; Branch_Taken_Id = 1'b0; Jump_Id = 1'b0;
        MD_Start_Id = 1'b0; MD_IsDiv_Id = 1'b0; MD_Use_Id = 1'b0;
    endtask

    initial begin
        logic done_seen;
        clear_in();
        rst = 1'b0;

        // reset forcing, even with an issue request present
        MD_Start_Id = 1'b1;
        #1;
        chk("rst_pcw",    32'(PC_Write),   32'd0);
        chk("rst_ifidw",  32'(IFID_Write), 32'd0);
        chk("rst_idexf",  32'(IDEX_Flush), 32'd1);
        chk("rst_ifidf",  32'(IFID_Flush), 32'd1);
        chk("rst_fire",   32'(MD_Fire),    32'd0);
        tick(); tick();
        chk("rst_busy",   32'(MD_Busy),    32'd0);
        chk("rst_done",   32'(MD_Done),    32'd0);
        chk("rst_scnt",   32'(Stall_Cnt),  32'd0);
        MD_Start_Id = 1'b0;
        rst = 1'b1;
        #1;
        chk("idle_pcw",   32'(PC_Write),   32'd1);
        chk("idle_idexf", 32'(IDEX_Flush), 32'd0);
        tick();

        // load-use on Rs
        MemRead_Ex = 1'b1; Rt_Ex = 5'd8; Rs_Id = 5'd8;
        #1;
        chk("lu_pcw",   32'(PC_Write),   32'd0);
        chk("lu_ifidw", 32'(IFID_Write), 32'd0);
        chk("lu_idexf", 32'(IDEX_Flush), 32'd1);
        chk("lu_ifidf", 32'(IFID_Flush), 32'd0);
        tick();
        MemRead_Ex = 1'b0;
        #1;
        chk("lu_rel_pcw",   32'(PC_Write),   32'd1);
        chk("lu_rel_idexf", 32'(IDEX_Flush), 32'd0);
        chk("lu_scnt",      32'(Stall_Cnt),  32'd1);
        tick();

        // load-use on Rt
        clear_in();
        MemRead_Ex = 1'b1; Rt_Ex = 5'd9; Rt_Id = 5'd9; Rs_Id = 5'd3;
        #1;
        chk("lurt_pcw", 32'(PC_Write), 32'd0);
        tick();
        // destination $zero never stalls
        clear_in();
        MemRead_Ex = 1'b1; Rt_Ex = 5'd0;
        #1;
        chk("lu0_pcw",  32'(PC_Write),  32'd1);
        chk("lu0_scnt", 32'(Stall_Cnt), 32'd2);
        tick();
        // matching register without MemRead is not a hazard
        clear_in();
        Rt_Ex = 5'd8; Rs_Id = 5'd8;
        #1;
        chk("nomr_pcw", 32'(PC_Write), 32'd1);
        tick();

        // branch vs stall
        clear_in();
        MemRead_Ex = 1'b1; Rt_Ex = 5'd8; Rs_Id = 5'd8; Branch_Taken_Id = 1'b1;
        #1;
        chk("brst_ifidf", 32'(IFID_Flush), 32'd0);
        chk("brst_pcw",   32'(PC_Write),   32'd0);
        tick();
        MemRead_Ex = 1'b0;
        #1;
        chk("br_ifidf", 32'(IFID_Flush), 32'd1);
        chk("br_pcw",   32'(PC_Write),   32'd1);
        tick();
        clear_in();
        Jump_Id = 1'b1;
        #1;
        chk("jmp_ifidf", 32'(IFID_Flush), 32'd1);
        chk("jmp_idexf", 32'(IDEX_Flush), 32'd0);
        tick();
        clear_in();
        #1;
        chk("br_scnt", 32'(Stall_Cnt), 32'd3);

        // DIV sequencing, MFLO waiting in ID from cycle 5
        MD_Start_Id = 1'b1; MD_IsDiv_Id = 1'b1;
        #1;
        chk("div_fire0", 32'(MD_Fire), 32'd1);
        chk("div_pcw0",  32'(PC_Write), 32'd1);
        tick();
        MD_Start_Id = 1'b0; MD_IsDiv_Id = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            MD_Use_Id = (c >= 5);
            #1;
            chk($sformatf("div_busy_c%0d", c), 32'(MD_Busy),  32'(c <= 32));
            chk($sformatf("div_done_c%0d", c), 32'(MD_Done),  32'(c == 33));
            chk($sformatf("div_pcw_c%0d", c),  32'(PC_Write), 32'(!(c >= 5 && c <= 32)));
            tick();
        end
        MD_Use_Id = 1'b0;
        #1;
        chk("div_done_c34", 32'(MD_Done),   32'd0);
        chk("div_scnt",     32'(Stall_Cnt), 32'd31);

        // back-to-back MULT: second MULT waits in ID, fires with the first MD_Done
        for (int c = 0; c <= 10; c++) begin
            MD_Start_Id = (c <= 5);
            MD_IsDiv_Id = 1'b0;
            #1;
            chk($sformatf("mul_fire_c%0d", c), 32'(MD_Fire),  32'(c == 0 || c == 5));
            chk($sformatf("mul_busy_c%0d", c), 32'(MD_Busy),
                32'((c >= 1 && c <= 4) || (c >= 6 && c <= 9)));
            chk($sformatf("mul_done_c%0d", c), 32'(MD_Done),  32'(c == 5 || c == 10));
            chk($sformatf("mul_pcw_c%0d", c),  32'(PC_Write), 32'(!(c >= 1 && c <= 4)));
            tick();
        end
        clear_in();
        #1;
        chk("mul_scnt", 32'(Stall_Cnt), 32'd35);

        // reset in the middle of a DIV
        MD_Start_Id = 1'b1; MD_IsDiv_Id = 1'b1;
        #1;
        chk("rdiv_fire", 32'(MD_Fire), 32'd1);
        tick();
        clear_in();
        repeat (9) tick();
        #1;
        chk("rdiv_busy10", 32'(MD_Busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("rdiv_idexf", 32'(IDEX_Flush), 32'd1);
        chk("rdiv_ifidf", 32'(IFID_Flush), 32'd1);
        chk("rdiv_pcw",   32'(PC_Write),   32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("rdiv_busy11", 32'(MD_Busy),   32'd0);
        chk("rdiv_scnt",   32'(Stall_Cnt), 32'd0);
        done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (MD_Done) done_seen = 1'b1;
            tick();
        end
        chk("rdiv_nodone", 32'(done_seen), 32'd0);

        // saturation of the stall counter under a permanent load-use
        MemRead_Ex = 1'b1; Rt_Ex = 5'd8; Rs_Id = 5'd8;
        repeat (65534) tick();
        chk("sat_fffe", 32'(Stall_Cnt), 32'h0000_FFFE);
        tick();
        chk("sat_ffff", 32'(Stall_Cnt), 32'h0000_FFFF);
        repeat (5) tick();
        chk("sat_hold", 32'(Stall_Cnt), 32'h0000_FFFF);
        clear_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage MIPS core. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve:
- load-use hazards, resolved by a 1-cycle stall and bubble;
- taken branches and jumps, resolved by an IF/ID flush;
- the multi-cycle MULT/DIV unit, sequenced by a busy counter that stalls dependent instructions.
It also keeps a saturating stall-cycle performance counter.

Parameters:
MUL_LAT, 4, cycles the MULT unit stays busy after issue (>=1)
DIV_LAT, 32, cycles the DIV unit stays busy after issue (>=1)
CNT_W, 6, width of the busy counter; must hold max(MUL_LAT, DIV_LAT)

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low
Rs_Id  input  5  IF/ID.RegisterRs
Rt_Id  input  5  IF/ID.RegisterRt
Rt_Ex  input  5  ID/EX.RegisterRt (load destination)
MemRead_Ex  input  1  ID/EX.MemRead
Branch_Taken_Id  input  1  branch resolved taken in ID
Jump_Id  input  1  J/JAL/JR in ID
MD_Start_Id  input  1  MULT/MULTU/DIV/DIVU in ID
MD_IsDiv_Id  input  1  1 = divide, 0 = multiply (valid with MD_Start_Id)
MD_Use_Id  input  1  MFHI/MFLO in ID
PC_Write  output  1  PC update enable
IFID_Write  output  1  IF/ID register load enable
IDEX_Flush  output  1  insert bubble into ID/EX
IFID_Flush  output  1  zero IF/ID (squash fetched instruction)
MD_Fire  output  1  issue strobe to the MULT/DIV unit
MD_Busy  output  1  MULT/DIV unit in operation
MD_Done  output  1  registered 1-cycle pulse: HI/LO valid
Stall_Cnt  output  16  saturating count of stall cycles

Behaviour:
- Reset: clk rising with rst=0. It sets state=IDLE, cnt=0, MD_Done=0, Stall_Cnt=0. rst=0 mid-operation aborts a MULT/DIV immediately; no MD_Done is produced.
- Reset output forcing: while rst=0, combinational outputs are PC_Write=0, IFID_Write=0, IDEX_Flush=1, IFID_Flush=1, MD_Fire=0.
- States:
  - IDLE: cnt==0.
  - BUSY: cnt!=0. MD_Busy = (state==BUSY).
- load_use = MemRead_Ex && Rt_Ex!=0 && (Rt_Ex==Rs_Id || Rt_Ex==Rt_Id).
- md_stall = BUSY && (MD_Start_Id || MD_Use_Id).
- stall = load_use || md_stall.
- When stall=1: PC_Write=0, IFID_Write=0, IDEX_Flush=1, IFID_Flush=0. Stall has priority over branch/jump, because branch operands may be the hazard; the branch re-resolves next cycle.
- When stall=0: PC_Write=1, IFID_Write=1, IDEX_Flush=0, IFID_Flush = Branch_Taken_Id || Jump_Id.
- Issue acceptance: MD_Fire = MD_Start_Id && !stall, only possible in IDLE. On the accepting edge, cnt <= MD_IsDiv_Id ? DIV_LAT : MUL_LAT.
- Countdown: in BUSY, cnt decrements by 1 each cycle. On the edge where cnt==1, cnt <= 0 (IDLE) and MD_Done <= 1. MD_Done is 0 in every other cycle.
- Issue timing: issue accepted in cycle t gives BUSY in cycles t+1..t+LAT and MD_Done=1 in cycle t+LAT+1.
- MFHI/MFLO in ID during the MD_Done cycle proceeds without stall.
- Back-to-back issue: a second MD_Start_Id stalls through BUSY and is accepted in the first IDLE cycle, which is also the MD_Done cycle of the first issue.
- Simultaneous load_use and md_stall: a single stall; Stall_Cnt increments by 1 only.
- Stall_Cnt: increments on each edge where stall=1 and rst=1. It saturates at 16'hFFFF with no wrap.
- Rt_Ex==0 never stalls, even with MemRead_Ex=1.

Test Plan:
- Load-use: MemRead_Ex=1, Rt_Ex=8, Rs_Id=8 for 1 cycle -> that cycle PC_Write=0, IFID_Write=0, IDEX_Flush=1; next cycle (MemRead_Ex=0) all normal; Stall_Cnt=1. Repeat with Rt_Ex=0 -> no stall.
- Branch vs stall: Branch_Taken_Id=1 with load_use=1 -> IFID_Flush=0, stall asserted. Next cycle load_use=0 -> IFID_Flush=1, PC_Write=1.
- DIV sequencing (DIV_LAT=32): MD_Start_Id=1, MD_IsDiv_Id=1 at cycle 0 -> MD_Fire=1 at 0; MD_Busy=1 cycles 1-32; MD_Done=1 only at cycle 33. MFLO held in ID from cycle 5 -> stalled cycles 5-32, released at 33; Stall_Cnt=28.
- Back-to-back MULT (MUL_LAT=4): issue at 0, second MULT in ID at 1 -> stalled 1-4; MD_Fire=1 at 5 coincident with MD_Done=1; second MD_Done at 10.
- Reset mid-op: rst=0 at cycle 10 of a DIV -> next cycle MD_Busy=0, Stall_Cnt=0, MD_Done never pulses. During rst=0, IDEX_Flush=1 and IFID_Flush=1.
- Saturation: hold load_use=1 for 65540 cycles -> Stall_Cnt=16'hFFFF and stays there.
